alu_bist_controller: RTL and testbench

On-chip built-in self-test controller for the 4-bit `ALU`. It sits on the opposite side of the ALU from the stimulus path:
- drives every `{Op, A, B}` combination into the ALU from an internal counter;
- compacts each `C` response into a 16-bit MISR;
- compares the final signature against a golden value and raises `Fault_Indicator` on mismatch.

It replaces bench-driven stimulus for production DFT runs.

---
 rtl/alu_bist_pkg.sv | 39 +++
 rtl/alu_bist_controller_misr16.sv | 29 ++
 rtl/alu_bist_controller.sv | 97 +++++++++
 tb/tb_alu_bist_controller.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_bist_pkg.sv
// Shared types and constants for the ALU built-in self-test controller.
`timescale 1ns/1ps
package alu_bist_pkg;

  localparam int          CNT_W     = 10;
  localparam logic [15:0] MISR_POLY = 16'h1021;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_COMPARE,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  // One ALU stimulus vector; its bit layout matches the pattern counter
  // so that Op=cnt[9:8], A=cnt[7:4], B=cnt[3:0].
  typedef struct packed {
    op_t        op;
    logic [3:0] a;
    logic [3:0] b;
  } pattern_t;

  // One MISR compaction step: CRC-16/CCITT shift with the response folded
  // into the low nibble.
  function automatic logic [15:0] misr_step(input logic [15:0] state,
                                            input logic [3:0]  data);
    misr_step = {state[14:0], 1'b0}
              ^ (state[15] ? MISR_POLY : 16'h0000)
              ^ {12'h000, data};
  endfunction

endpackage

// File: rtl/alu_bist_controller_misr16.sv
// 16-bit multiple-input signature register with synchronous seed load.
`timescale 1ns/1ps
module misr16
  import alu_bist_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        en,
  input  logic [3:0]  d,
  output logic [15:0] q
);

  // Signature state: seed on reset or load, compact d when enabled.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (rst) begin
      q <= SEED;
    end else if (load) begin
      q <= SEED;
    end else if (en) begin
      q <= misr_step(q, d);
    end
  end

endmodule

// File: rtl/alu_bist_controller.sv
// BIST controller: walks every {Op, A, B} vector into the ALU, compacts the
// responses in a MISR and flags a mismatch against the golden signature.
`timescale 1ns/1ps
module alu_bist_controller
  import alu_bist_pkg::*;
#(
  parameter int          NUM_PATTERNS = 1024,
  parameter logic [15:0] MISR_SEED    = 16'hFFFF,
  parameter logic [15:0] GOLDEN_SIG   = 16'h0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [3:0]  C,
  output logic [3:0]  A,
  output logic [3:0]  B,
  output logic [1:0]  Op,
  output logic        Busy,
  output logic        Done,
  output logic        Fault_Indicator,
  output logic [15:0] Signature
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  pattern_t          pattern;
  logic [15:0]       misr_q;
  logic              misr_load;
  logic              misr_en;

  // A run starts only from IDLE or DONE; compaction happens only in RUN.
  assign misr_load = Start && (state == ST_IDLE || state == ST_DONE);
  assign misr_en   = (state == ST_RUN);

  misr16 #(
    .SEED (MISR_SEED)
  ) u_misr (
    .clk  (Clk),
    .rst  (Rst),
    .load (misr_load),
    .en   (misr_en),
    .d    (C),
    .q    (misr_q)
  );

  // Stimulus outputs come straight from the pattern register.
  assign Op = pattern.op;
  assign A  = pattern.a;
  assign B  = pattern.b;

  // Sequencer: state, pattern counter and all registered status outputs.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      pattern         <= '0;
      Busy            <= 1'b0;
      Done            <= 1'b0;
      Fault_Indicator <= 1'b0;
      Signature       <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (Start) begin
            state           <= ST_RUN;
            cnt             <= '0;
            pattern         <= '0;
            Busy            <= 1'b1;
            Done            <= 1'b0;
            Fault_Indicator <= 1'b0;
          end
        end
        ST_RUN: begin
          if (cnt == LAST_CNT) begin
            // Counter parks on the last pattern; stimulus returns to zero.
            state   <= ST_COMPARE;
            pattern <= '0;
          end else begin
            cnt     <= cnt + CNT_W'(1);
            pattern <= pattern_t'(cnt + CNT_W'(1));
          end
        end
        ST_COMPARE: begin
          Signature       <= misr_q;
          Fault_Indicator <= (misr_q != GOLDEN_SIG);
          Busy            <= 1'b0;
          Done            <= 1'b1;
          state           <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist_controller.sv
// Directed self-checking bench for alu_bist_controller: a one-pattern
// instance with a tied-off C, and a full 1024-pattern instance driving a
// behavioural ALU model.
`timescale 1ns/1ps
module tb_alu_bist_controller;

  localparam int N_FULL = 1024;

  // Behavioural 4-bit ALU; divide by zero returns all ones.
  function automatic logic [3:0] alu_f(input logic [1:0] op,
                                       input logic [3:0] a,
                                       input logic [3:0] b);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a * b;
      default: return (b == 4'h0) ? 4'hF : a / b;
    endcase
  endfunction

  // Reference signature over the full pattern sweep, optionally with C[0]
  // stuck at one.
  function automatic logic [15:0] ref_sig(input logic stuck);
    logic [15:0] s;
    logic [9:0]  p;
    logic [3:0]  c;
    s = 16'hFFFF;
    for (int i = 0; i < N_FULL; i++) begin
      p = 10'(i);
      c = alu_f(p[9:8], p[7:4], p[3:0]);
      if (stuck) c[0] = 1'b1;
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {12'h000, c};
    end
    return s;
  endfunction

  localparam logic [15:0] REF_SIG = ref_sig(1'b0);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_s = 1'b0;
  logic        start_b = 1'b0;
  logic [3:0]  c_s = 4'h0;
  logic        stuck = 1'b0;

  logic [3:0]  a_s, b_s, a_b, b_b, c_b;
  logic [1:0]  op_s, op_b;
  logic        busy_s, done_s, fault_s, busy_b, done_b, fault_b;
  logic [15:0] sig_s, sig_b;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  always_comb begin
    c_b = alu_f(op_b, a_b, b_b);
    if (stuck) c_b[0] = 1'b1;
  end

  alu_bist_controller #(
    .NUM_PATTERNS (1),
    .MISR_SEED    (16'hFFFF),
    .GOLDEN_SIG   (16'hEFDF)
  ) dut_s (
    .Clk (clk), .Rst (rst), .Start (start_s), .C (c_s),
    .A (a_s), .B (b_s), .Op (op_s),
    .Busy (busy_s), .Done (done_s), .Fault_Indicator (fault_s), .Signature (sig_s)
  );

  alu_bist_controller #(
    .NUM_PATTERNS (N_FULL),
    .MISR_SEED    (16'hFFFF),
    .GOLDEN_SIG   (REF_SIG)
  ) dut (
    .Clk (clk), .Rst (rst), .Start (start_b), .C (c_b),
    .A (a_b), .B (b_b), .Op (op_b),
    .Busy (busy_b), .Done (done_b), .Fault_Indicator (fault_b), .Signature (sig_b)
  );

  // Runs one BIST pass on the chosen instance, starting from a negedge.
  // done_cyc counts edges after the Start edge until Done is seen (-1 if
  // never within budget); a Start pulse is injected at cycle pulse_at.
  task automatic run(input bit big, input int pulse_at,
                     output int busy_cnt, output int done_cyc,
                     output int pat_err, output int bad_idx);
    int n;
    logic [9:0] obs, exp;
    n = big ? N_FULL : 1;
    busy_cnt = 0; done_cyc = -1; pat_err = 0; bad_idx = -1;
    if (big) start_b = 1'b1; else start_s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_b = 1'b0; start_s = 1'b0;
    for (int cyc = 0; cyc < n + 20; cyc++) begin
      if (big) start_b = (cyc == pulse_at);
      obs = big ? {op_b, a_b, b_b} : {op_s, a_s, b_s};
      exp = (cyc < n) ? 10'(cyc) : 10'h000;
      if (obs !== exp) begin
        if (pat_err == 0) bad_idx = cyc;
        pat_err++;
      end
      if (big ? busy_b : busy_s) busy_cnt++;
      if (big ? done_b : done_s) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    start_b = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests_run++; if (busy_b !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy_b); end
    tests_run++; if (done_b !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", done_b); end
    tests_run++; if (fault_b !== 1'b0) begin tests_failed++; $display("FAIL reset_fault got %b want 0", fault_b); end
    tests_run++; if (sig_b !== 16'h0000) begin tests_failed++; $display("FAIL reset_sig got %h want 0000", sig_b); end
    tests_run++; if ({op_b, a_b, b_b} !== 10'h000) begin tests_failed++; $display("FAIL reset_pattern got %h want 000", {op_b, a_b, b_b}); end
    tests_run++; if (sig_s !== 16'h0000) begin tests_failed++; $display("FAIL reset_sig_small got %h want 0000", sig_s); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_misr_single_step();
    int bc, dc, pe, bi;
    c_s = 4'h0;
    run(1'b0, -1, bc, dc, pe, bi);
    tests_run++; if (sig_s !== 16'hEFDF) begin tests_failed++; $display("FAIL step_c0_sig got %h want efdf", sig_s); end
    tests_run++; if (fault_s !== 1'b0) begin tests_failed++; $display("FAIL step_c0_fault got %b want 0", fault_s); end
    tests_run++; if (bc != 2) begin tests_failed++; $display("FAIL step_busy_cycles got %0d want 2", bc); end
    tests_run++; if (dc != 2) begin tests_failed++; $display("FAIL step_done_latency got %0d want 2", dc); end
    tests_run++; if (pe != 0) begin tests_failed++; $display("FAIL step_pattern errors %0d first at %0d want 0", pe, bi); end
    c_s = 4'h3;
    run(1'b0, -1, bc, dc, pe, bi);
    tests_run++; if (sig_s !== 16'hEFDC) begin tests_failed++; $display("FAIL step_c3_sig got %h want efdc", sig_s); end
    tests_run++; if (fault_s !== 1'b1) begin tests_failed++; $display("FAIL step_c3_fault got %b want 1", fault_s); end
    tests_run++; if (dc != 2) begin tests_failed++; $display("FAIL step_c3_done_latency got %0d want 2", dc); end
  endtask

  task automatic test_full_run();
    int bc, dc, pe, bi;
    run(1'b1, -1, bc, dc, pe, bi);
    tests_run++; if (pe != 0) begin tests_failed++; $display("FAIL full_pattern errors %0d first at %0d want 0", pe, bi); end
    tests_run++; if (sig_b !== REF_SIG) begin tests_failed++; $display("FAIL full_sig got %h want %h", sig_b, REF_SIG); end
    tests_run++; if (fault_b !== 1'b0) begin tests_failed++; $display("FAIL full_fault got %b want 0", fault_b); end
    tests_run++; if (bc != N_FULL + 1) begin tests_failed++; $display("FAIL full_busy_cycles got %0d want %0d", bc, N_FULL + 1); end
    tests_run++; if (dc != N_FULL + 1) begin tests_failed++; $display("FAIL full_done_latency got %0d want %0d", dc, N_FULL + 1); end
  endtask

  task automatic test_stuck_at();
    int bc, dc, pe, bi;
    logic [15:0] exp_sig;
    exp_sig = ref_sig(1'b1);
    stuck = 1'b1;
    run(1'b1, -1, bc, dc, pe, bi);
    stuck = 1'b0;
    tests_run++; if (fault_b !== 1'b1) begin tests_failed++; $display("FAIL stuck_fault got %b want 1", fault_b); end
    tests_run++; if (sig_b === REF_SIG) begin tests_failed++; $display("FAIL stuck_sig got %h want not %h", sig_b, REF_SIG); end
    tests_run++; if (sig_b !== exp_sig) begin tests_failed++; $display("FAIL stuck_sig_model got %h want %h", sig_b, exp_sig); end
  endtask

  task automatic test_start_ignored();
    int bc, dc, pe, bi;
    run(1'b1, 100, bc, dc, pe, bi);
    tests_run++; if (dc != N_FULL + 1) begin tests_failed++; $display("FAIL ignore_done_latency got %0d want %0d", dc, N_FULL + 1); end
    tests_run++; if (sig_b !== REF_SIG) begin tests_failed++; $display("FAIL ignore_sig got %h want %h", sig_b, REF_SIG); end
    tests_run++; if (pe != 0) begin tests_failed++; $display("FAIL ignore_pattern errors %0d first at %0d want 0", pe, bi); end
  endtask

  task automatic test_reset_mid_run();
    int bc, dc, pe, bi;
    start_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_b = 1'b0;
    repeat (500) @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++; if (busy_b !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy got %b want 0", busy_b); end
    tests_run++; if (done_b !== 1'b0) begin tests_failed++; $display("FAIL midrst_done got %b want 0", done_b); end
    tests_run++; if (sig_b !== 16'h0000) begin tests_failed++; $display("FAIL midrst_sig got %h want 0000", sig_b); end
    tests_run++; if ({op_b, a_b, b_b} !== 10'h000) begin tests_failed++; $display("FAIL midrst_pattern got %h want 000", {op_b, a_b, b_b}); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run(1'b1, -1, bc, dc, pe, bi);
    tests_run++; if (sig_b !== REF_SIG) begin tests_failed++; $display("FAIL midrst_rerun_sig got %h want %h", sig_b, REF_SIG); end
    tests_run++; if (fault_b !== 1'b0) begin tests_failed++; $display("FAIL midrst_rerun_fault got %b want 0", fault_b); end
    tests_run++; if (dc != N_FULL + 1) begin tests_failed++; $display("FAIL midrst_rerun_latency got %0d want %0d", dc, N_FULL + 1); end
  endtask

  task automatic test_back_to_back();
    int bc, dc, pe, bi;
    tests_run++; if (done_b !== 1'b1) begin tests_failed++; $display("FAIL b2b_in_done got %b want 1", done_b); end
    run(1'b1, -1, bc, dc, pe, bi);
    tests_run++; if (dc != N_FULL + 1) begin tests_failed++; $display("FAIL b2b_done_latency got %0d want %0d", dc, N_FULL + 1); end
    tests_run++; if (sig_b !== REF_SIG) begin tests_failed++; $display("FAIL b2b_sig got %h want %h", sig_b, REF_SIG); end
    tests_run++; if (fault_b !== 1'b0) begin tests_failed++; $display("FAIL b2b_fault got %b want 0", fault_b); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_misr_single_step();
    test_full_run();
    test_stuck_at();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
